// File: rtl/cal_rx.sv
// cal_rx: measures the period of an asynchronous calibration waveform in
// system clocks, checks it against the expected division setting (+/-1 clock),
// and reports each measurement, lock after 4 good periods, errors and timeouts.
module cal_rx (
  input  logic       calrx_clkin,
  input  logic       calrx_reset,
  input  logic       calrx_en,
  input  logic       calrx_load,
  input  logic [5:0] calrx_divcount,
  input  logic       calrx_in,
  output logic [7:0] calrx_period,
  output logic       calrx_valid,
  output logic       calrx_lock,
  output logic       calrx_err,
  output logic       calrx_timeout
);

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned GOOD_W    = 3;
  localparam int unsigned LOCK_GOOD = 4;
  localparam int unsigned CNT_MAX   = 254;
  localparam int unsigned EXP_RST   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEEK,
    ST_MEASURE,
    ST_LOCKED
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_s1;
  logic                r_s2;
  logic                r_s3;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]    r_exp_p;
  logic [CNT_W-1:0]    w_exp_nxt;
  logic [CNT_W-1:0]    w_period_nxt;
  logic [CNT_W-1:0]    w_meas;
  logic [CNT_W-1:0]    w_exp_load;
  logic [GOOD_W-1:0]   r_good_cnt;
  logic [GOOD_W-1:0]   w_good_nxt;
  logic                w_lock_nxt;
  logic                w_valid_nxt;
  logic                w_err_nxt;
  logic                w_timeout_nxt;
  logic                w_rise;
  logic                w_good;
  logic signed [CNT_W:0] w_diff;

  // Rise detect on the synchronized waveform; period = clocks since last rise.
  assign w_rise     = r_s2 & ~r_s3;
  assign w_meas     = r_cnt + CNT_W'(1);
  assign w_exp_load = CNT_W'({calrx_divcount, 1'b0}) + CNT_W'(2);
  assign w_diff     = $signed({1'b0, w_meas}) - $signed({1'b0, r_exp_p});
  assign w_good     = (w_diff == 9'sd0) || (w_diff == 9'sd1) || (w_diff == -9'sd1);

  // Two-flop synchronizer followed by an edge-detect flop.
  always_ff @(posedge calrx_clkin) begin
    if (calrx_reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= calrx_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // State register and registered datapath/outputs.
  always_ff @(posedge calrx_clkin) begin
    if (calrx_reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_good_cnt    <= '0;
      r_exp_p       <= CNT_W'(EXP_RST);
      calrx_period  <= '0;
      calrx_valid   <= 1'b0;
      calrx_lock    <= 1'b0;
      calrx_err     <= 1'b0;
      calrx_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_good_cnt    <= w_good_nxt;
      r_exp_p       <= w_exp_nxt;
      calrx_period  <= w_period_nxt;
      calrx_valid   <= w_valid_nxt;
      calrx_lock    <= w_lock_nxt;
      calrx_err     <= w_err_nxt;
      calrx_timeout <= w_timeout_nxt;
    end
  end

  // Next state: disable > load > timeout > rise.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_good_nxt    = r_good_cnt;
    w_exp_nxt     = r_exp_p;
    w_period_nxt  = calrx_period;
    w_lock_nxt    = calrx_lock;
    w_valid_nxt   = 1'b0;
    w_err_nxt     = 1'b0;
    w_timeout_nxt = 1'b0;

    if (calrx_load) begin
      w_exp_nxt = w_exp_load;
    end

    if (!calrx_en) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_good_nxt  = '0;
      w_lock_nxt  = 1'b0;
    end else if (calrx_load) begin
      w_state_nxt = ST_SEEK;
      w_cnt_nxt   = '0;
      w_good_nxt  = '0;
      w_lock_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_SEEK;
          w_cnt_nxt   = '0;
          w_good_nxt  = '0;
        end
        ST_SEEK: begin
          w_cnt_nxt = '0;
          if (w_rise) begin
            w_state_nxt = ST_MEASURE;
          end
        end
        ST_MEASURE, ST_LOCKED: begin
          if (r_cnt == CNT_W'(CNT_MAX)) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = ST_SEEK;
            w_cnt_nxt     = '0;
            w_good_nxt    = '0;
            w_lock_nxt    = 1'b0;
          end else if (w_rise) begin
            w_cnt_nxt    = '0;
            w_period_nxt = w_meas;
            w_valid_nxt  = 1'b1;
            if (w_good) begin
              if (r_good_cnt < GOOD_W'(LOCK_GOOD)) begin
                w_good_nxt = r_good_cnt + GOOD_W'(1);
              end
              if (w_good_nxt == GOOD_W'(LOCK_GOOD)) begin
                w_lock_nxt  = 1'b1;
                w_state_nxt = ST_LOCKED;
              end
            end else begin
              w_err_nxt   = 1'b1;
              w_good_nxt  = '0;
              w_lock_nxt  = 1'b0;
              w_state_nxt = ST_MEASURE;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cal_rx.md
# cal_rx

Calibration-signal receiver: the measuring end of the calibration pulse generator's divided-clock output. It synchronizes the incoming calibration waveform, measures its period in system clocks, and compares it against the expected division setting. It reports each measurement, a lock indication after consecutive good periods, and error and timeout pulses. It sits in the calibration path beside the generator so firmware can confirm that the calibration tone is present and correctly divided.

## Interface
- No parameters. Counter width is fixed at 8 bits, the lock threshold at 4 good periods, and the tolerance at ±1 clock.
- calrx_clkin  in  1  system clock; all logic is on its rising edge.
- calrx_reset  in  1  synchronous, active-high reset.
- calrx_en  in  1  enable; low forces IDLE.
- calrx_load  in  1  single-cycle strobe; latches calrx_divcount and restarts acquisition.
- calrx_divcount  in  6  division setting; expected period P = 2*(divcount+1) clocks, range 2..128.
- calrx_in  in  1  calibration waveform, asynchronous to calrx_clkin.
- calrx_period  out  8  last measured period in clocks.
- calrx_valid  out  1  one-cycle pulse when calrx_period updates.
- calrx_lock  out  1  level; high after 4 consecutive in-tolerance periods.
- calrx_err  out  1  one-cycle pulse on an out-of-tolerance period.
- calrx_timeout  out  1  one-cycle pulse when no rising edge arrives within 255 clocks.

## Operation
- Input path: calrx_in passes through a 2-flop synchronizer (s1, s2), then an edge flop s3. A rise is detected when s2 & ~s3.
- Expected register exp_p[7:0] is loaded with 2*(divcount+1) on calrx_load. It resets to 2, which corresponds to divcount=0.
- Period counter cnt[7:0]:
  - Cleared to 0 on a rise; otherwise increments every cycle.
  - At a rise, the measured period is cnt+1, computed in 8 bits with no overflow because cnt never exceeds 254.
- Good period: |meas - exp_p| ≤ 1, computed as a 9-bit signed difference.
- Good-period counter good_cnt[2:0] saturates at 4.
- States:
  - IDLE: counters are held at 0. Go to SEEK when calrx_en=1.
  - SEEK: wait for the first rise. On that rise, clear cnt and go to MEASURE. No calrx_valid is issued, because there is no reference edge yet.
  - MEASURE: on each rise, update calrx_period and pulse calrx_valid.
    - Good period: increment good_cnt. When it reaches 4, set calrx_lock and go to LOCKED.
    - Bad period: pulse calrx_err and clear good_cnt.
  - LOCKED: on each rise, update calrx_period and pulse calrx_valid. A bad period pulses calrx_err, clears calrx_lock and good_cnt, and returns to MEASURE.
- Timeout: in MEASURE or LOCKED, if cnt reaches 254 with no rise, the next cycle pulses calrx_timeout, clears calrx_lock and good_cnt, and goes to SEEK.
- Priority, highest first: calrx_reset, calrx_en=0 (→ IDLE, lock cleared), calrx_load (→ SEEK, lock and good_cnt cleared, any same-cycle rise ignored), timeout, rise.
- calrx_period holds its last value through IDLE, SEEK and load. Only reset clears it.

## Timing
- Reset values: calrx_period=0, calrx_valid=0, calrx_lock=0, calrx_err=0, calrx_timeout=0, state=IDLE, cnt=0, good_cnt=0, exp_p=2, s1=s2=s3=0.
- Latency:
  - If calrx_in rises before clock edge k, s1 captures it at k and s2 at k+1.
  - The rise is detected during the cycle k+1..k+2.
  - calrx_valid, calrx_err and calrx_period update registered at edge k+2.
  - calrx_lock rises at the same edge as the 4th good calrx_valid.
- calrx_err and calrx_lock deassertion coincide with calrx_valid on a bad period.
- Timeout pulse fires exactly 255 clocks after the last rise was registered.
- calrx_load takes effect at the next edge. The new exp_p applies to the first measurement after re-acquisition.
- Minimum measurable period is 2 clocks. Any calrx_in high or low phase shorter than one clock may be missed; this is not detected.

## Test plan
- Reset: assert calrx_reset for 3 clocks while calrx_in toggles. Required: all outputs 0, state IDLE, and no calrx_valid for 2 cycles after release.
- Lock acquisition: load divcount=4 (P=10), calrx_en=1, drive calrx_in with period 10. Required:
  - First calrx_valid on the second rise, calrx_period=10.
  - calrx_lock=1 coincides with the 4th calrx_valid.
  - Each calrx_valid occurs exactly 3 edges after the driven rise.
- Tolerance: while locked at P=10, apply periods 9 and 11. Required: lock holds and calrx_period shows 9 and 11. Then apply period 13. Required: calrx_err pulse with calrx_period=13 and calrx_lock=0 on the same edge; relock after 4 further good periods.
- Timeout: while locked, hold calrx_in low. Required: calrx_timeout pulse 255 clocks after the last registered rise, calrx_lock=0, and the next rise produces no calrx_valid.
- Load and disable mid-operation:
  - calrx_load with divcount=63 while locked. Required: lock drops the next edge, and a 128-clock input period locks after 5 rises.
  - calrx_en=0. Required: IDLE and no pulses.
- Boundary: divcount=0 with a period-2 input. Required: calrx_period=2 and lock. Simultaneous calrx_load and rise: required, the rise is ignored.
